// File: rtl/uart_sched_pkg.sv
// Shared types for the UART TX scheduler.
// Scheduler FSM states and the byte width.
package uart_sched_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_HI,
    WAIT_LO
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr,
// wrapping cyclically. Purely combinational.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW:0]   pos;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(N))
        pos = pos - (IW+1)'(N);
      if (!found && req[pos[IW-1:0]]) begin
        found               = 1'b1;
        gnt[pos[IW-1:0]]    = 1'b1;
        idx                 = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between NUM_REQ byte requesters,
// granting round-robin bursts that end on last, MAX_BURST or dry.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16,
  parameter int BUSY_TMO  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_start,
  output logic [BYTE_W-1:0]          tx_data,
  input  logic                       tx_busy,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       sched_busy,
  output logic                       byte_done,
  output logic                       err_tmo
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(BUSY_TMO);
  localparam logic [TW-1:0] TMO_LAST  = TW'(BUSY_TMO - 1);
  localparam logic [7:0]    BURST_MAX = 8'(MAX_BURST);

  state_e              state_q,     state_d;
  logic [NUM_REQ-1:0]  grant_q,     grant_d;
  logic [IW-1:0]       owner_q,     owner_d;
  logic [IW-1:0]       rr_ptr_q,    rr_ptr_d;
  logic [7:0]          burst_cnt_q, burst_cnt_d;
  logic [TW-1:0]       tmo_cnt_q,   tmo_cnt_d;
  logic [BYTE_W-1:0]   tx_data_q,   tx_data_d;
  logic                last_q,      last_d;
  logic                err_tmo_q,   err_tmo_d;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IW-1:0]       arb_idx;
  logic [IW-1:0]       ptr_next;
  logic [BYTE_W-1:0]   req_bytes [NUM_REQ];

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      req_bytes[i] = req_data[i*BYTE_W +: BYTE_W];
  end

  assign ptr_next = (owner_q == IW'(NUM_REQ - 1)) ? '0
                  : owner_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      tx_data_q   <= '0;
      last_q      <= 1'b0;
      err_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      tx_data_q   <= tx_data_d;
      last_q      <= last_d;
      err_tmo_q   <= err_tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    tx_data_d   = tx_data_q;
    last_d      = last_q;
    err_tmo_d   = err_tmo_q;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant_d     = arb_gnt;
          owner_d     = arb_idx;
          burst_cnt_d = '0;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        if (req_valid[owner_q]) begin
          tx_data_d   = req_bytes[owner_q];
          last_d      = req_last[owner_q];
          burst_cnt_d = burst_cnt_q + 1'b1;
          state_d     = START;
        end else begin
          grant_d  = '0;
          rr_ptr_d = ptr_next;
          state_d  = IDLE;
        end
      end
      START: begin
        tmo_cnt_d = '0;
        state_d   = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_d = WAIT_LO;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
          if (tmo_cnt_d == TMO_LAST) begin
            err_tmo_d = 1'b1;
            grant_d   = '0;
            rr_ptr_d  = ptr_next;
            state_d   = IDLE;
          end
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (last_q || burst_cnt_q == BURST_MAX) begin
            grant_d  = '0;
            rr_ptr_d = ptr_next;
            state_d  = IDLE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are masked during rst so an aborted frame never signals.
  always_comb begin
    req_ready = '0;
    tx_start  = 1'b0;
    byte_done = 1'b0;
    if (!rst) begin
      unique case (state_q)
        LOAD:    if (req_valid[owner_q]) req_ready = grant_q;
        START:   tx_start  = 1'b1;
        WAIT_LO: byte_done = !tx_busy;
        default: ;
      endcase
    end
  end

  assign grant      = grant_q;
  assign sched_busy = |grant_q;
  assign tx_data    = tx_data_q;
  assign err_tmo    = err_tmo_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: requester queues feed
// the DUTs, a monitor checks every tx_start against expectations.
module tb_uart_tx_scheduler;

  typedef struct {
    logic [7:0] d;
    logic       last;
  } byte_t;

  typedef struct {
    logic [3:0] g;
    logic [7:0] d;
    int         gap;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        core_dead;

  logic [3:0]  req_valid_a, req_last_a, req_ready_a, grant_a;
  logic [31:0] req_data_a;
  logic        tx_start_a, tx_busy_a, sched_busy_a;
  logic        byte_done_a, err_tmo_a;
  logic [7:0]  tx_data_a;

  logic [3:0]  req_valid_b, req_last_b, req_ready_b, grant_b;
  logic [31:0] req_data_b;
  logic        tx_start_b, tx_busy_b, sched_busy_b;
  logic        byte_done_b, err_tmo_b;
  logic [7:0]  tx_data_b;

  uart_tx_scheduler #(
    .NUM_REQ(4), .MAX_BURST(16), .BUSY_TMO(64)
  ) u_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_a), .req_data(req_data_a),
    .req_last(req_last_a), .req_ready(req_ready_a),
    .tx_start(tx_start_a), .tx_data(tx_data_a),
    .tx_busy(tx_busy_a), .grant(grant_a),
    .sched_busy(sched_busy_a), .byte_done(byte_done_a),
    .err_tmo(err_tmo_a)
  );

  uart_tx_scheduler #(
    .NUM_REQ(4), .MAX_BURST(2), .BUSY_TMO(64)
  ) u_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_data(req_data_b),
    .req_last(req_last_b), .req_ready(req_ready_b),
    .tx_start(tx_start_b), .tx_data(tx_data_b),
    .tx_busy(tx_busy_b), .grant(grant_b),
    .sched_busy(sched_busy_b), .byte_done(byte_done_b),
    .err_tmo(err_tmo_b)
  );

  // TX core models: busy for a fixed frame time after tx_start
  int bcnt_a, bcnt_b;

  always @(posedge clk) begin
    if (rst)                          bcnt_a <= 0;
    else if (tx_start_a && !core_dead) bcnt_a <= 10;
    else if (bcnt_a != 0)             bcnt_a <= bcnt_a - 1;
  end

  always @(posedge clk) begin
    if (rst)              bcnt_b <= 0;
    else if (tx_start_b)  bcnt_b <= 3;
    else if (bcnt_b != 0) bcnt_b <= bcnt_b - 1;
  end

  assign tx_busy_a = (bcnt_a != 0);
  assign tx_busy_b = (bcnt_b != 0);

  byte_t rq_a [4][$];
  byte_t rq_b [4][$];
  exp_t  exp_a [$];
  exp_t  exp_b [$];

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;
  int done_a   = 0;
  int done_b   = 0;
  int last_done_a  = 0;
  int last_done_b  = 0;
  int last_start_a = 0;
  logic [7:0] held_a = 8'h00;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_valid_a[i]     = rq_a[i].size() != 0;
      req_data_a[i*8+:8] = (rq_a[i].size() != 0) ? rq_a[i][0].d : 8'h00;
      req_last_a[i]      = (rq_a[i].size() != 0) ? rq_a[i][0].last : 1'b0;
      req_valid_b[i]     = rq_b[i].size() != 0;
      req_data_b[i*8+:8] = (rq_b[i].size() != 0) ? rq_b[i][0].d : 8'h00;
      req_last_b[i]      = (rq_b[i].size() != 0) ? rq_b[i][0].last : 1'b0;
    end
  endtask

  task automatic push_a(input int r, input logic [7:0] dat,
                        input logic lst, input int gp);
    byte_t b;
    exp_t  e;
    b.d = dat; b.last = lst;
    e.g = 4'(1 << r); e.d = dat; e.gap = gp;
    rq_a[r].push_back(b);
    exp_a.push_back(e);
    drive();
  endtask

  task automatic push_b(input int r, input logic [7:0] dat,
                        input logic lst, input int gp);
    byte_t b;
    exp_t  e;
    b.d = dat; b.last = lst;
    e.g = 4'(1 << r); e.d = dat; e.gap = gp;
    rq_b[r].push_back(b);
    exp_b.push_back(e);
    drive();
  endtask

  function automatic bit quiet(input bit use_b);
    bit q;
    q = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (!use_b && rq_a[i].size() != 0) q = 1'b0;
      if ( use_b && rq_b[i].size() != 0) q = 1'b0;
    end
    if (use_b) return q && exp_b.size() == 0 && grant_b == 4'h0 && !tx_busy_b;
    return q && exp_a.size() == 0 && grant_a == 4'h0 && !tx_busy_a;
  endfunction

  task automatic wait_idle(input bit use_b, input int budget,
                           input string nm);
    int n = 0;
    @(negedge clk);
    while (!quiet(use_b)) begin
      if (n >= budget) begin
        chk_cnt++;
        $display("FAIL %s: timeout after %0d cycles", nm, n);
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  initial begin : cycle_ctr
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Requesters pop a byte after the edge that accepted it
  initial begin : feeder
    logic [3:0] ra, rb;
    forever begin
      @(negedge clk);
      ra = req_ready_a;
      rb = req_ready_b;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (ra[i] && rq_a[i].size() != 0) rq_a[i].delete(0);
        if (rb[i] && rq_b[i].size() != 0) rq_b[i].delete(0);
      end
      drive();
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (tx_start_a) begin
        if (exp_a.size() == 0) begin
          chk_cnt++;
          $display("FAIL a_start: got unexpected byte %0h expected none", tx_data_a);
        end else begin
          e = exp_a.pop_front();
          chk("a_grant", 32'(grant_a), 32'(e.g));
          chk("a_data", 32'(tx_data_a), 32'(e.d));
          if (e.gap >= 0) chk("a_gap", cyc - last_done_a, e.gap);
        end
        last_start_a = cyc;
        held_a       = tx_data_a;
      end
      if (byte_done_a) begin
        done_a++;
        last_done_a = cyc;
        chk("a_hold", 32'(tx_data_a), 32'(held_a));
      end
      if (tx_start_b) begin
        if (exp_b.size() == 0) begin
          chk_cnt++;
          $display("FAIL b_start: got unexpected byte %0h expected none", tx_data_b);
        end else begin
          e = exp_b.pop_front();
          chk("b_grant", 32'(grant_b), 32'(e.g));
          chk("b_data", 32'(tx_data_b), 32'(e.d));
          if (e.gap >= 0) chk("b_gap", cyc - last_done_b, e.gap);
        end
      end
      if (byte_done_b) begin
        done_b++;
        last_done_b = cyc;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin : stim
    int d0;
    int n;
    rst       = 1'b1;
    core_dead = 1'b0;
    drive();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_grant", 32'(grant_a), 0);
    chk("rst_sbusy", 32'(sched_busy_a), 0);
    chk("rst_start", 32'(tx_start_a), 0);
    chk("rst_ready", 32'(req_ready_a), 0);
    chk("rst_err", 32'(err_tmo_a), 0);
    chk("rst_txd", 32'(tx_data_a), 0);
    chk("rst_grant_b", 32'(grant_b), 0);

    // 1: single requester, three bytes
    @(posedge clk); #1;
    d0 = done_a;
    push_a(0, 8'hA5, 1'b0, -1);
    push_a(0, 8'h5A, 1'b0, 2);
    push_a(0, 8'hFF, 1'b1, 2);
    wait_idle(1'b0, 400, "t1_wait");
    chk("t1_done", done_a - d0, 3);
    chk("t1_grant", 32'(grant_a), 0);
    chk("t1_err", 32'(err_tmo_a), 0);

    // 2: four endless streams, two bytes per grant
    @(posedge clk); #1;
    d0 = done_b;
    for (int r = 0; r < 4; r++) begin
      push_b(r, 8'(r*16),     1'b0, (r == 0) ? -1 : 3);
      push_b(r, 8'(r*16 + 1), 1'b0, 2);
    end
    push_b(0, 8'h02, 1'b0, 3);
    push_b(0, 8'h03, 1'b0, 2);
    wait_idle(1'b1, 600, "t2_wait");
    chk("t2_done", done_b - d0, 10);
    chk("t2_grant", 32'(grant_b), 0);

    // 3: requester 2 runs dry, requester 3 waiting
    @(posedge clk); #1;
    push_a(2, 8'h21, 1'b0, -1);
    push_a(3, 8'h31, 1'b1, 4);
    n = 0;
    while (grant_a != 4'b1000 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t3_grant", 32'(grant_a), 32'h8);
    chk("t3_rr_ptr", 32'(u_a.rr_ptr_q), 3);
    wait_idle(1'b0, 400, "t3_wait");

    // 4: core never responds
    @(posedge clk); #1;
    core_dead = 1'b1;
    d0 = done_a;
    push_a(1, 8'h3C, 1'b1, -1);
    n = 0;
    while (!err_tmo_a && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("t4_latency", cyc - last_start_a, 64);
    chk("t4_grant", 32'(grant_a), 0);
    chk("t4_sbusy", 32'(sched_busy_a), 0);
    repeat (20) @(negedge clk);
    chk("t4_sticky", 32'(err_tmo_a), 1);
    chk("t4_done", done_a - d0, 0);
    @(posedge clk); #1;
    core_dead = 1'b0;

    // 5: reset in the middle of a frame
    d0 = done_a;
    push_a(2, 8'h77, 1'b1, -1);
    n = 0;
    while (!tx_busy_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_grant", 32'(grant_a), 0);
    chk("t5_sbusy", 32'(sched_busy_a), 0);
    chk("t5_start", 32'(tx_start_a), 0);
    chk("t5_ready", 32'(req_ready_a), 0);
    chk("t5_bdone", 32'(byte_done_a), 0);
    chk("t5_err", 32'(err_tmo_a), 0);
    chk("t5_txd", 32'(tx_data_a), 0);
    chk("t5_done", done_a - d0, 0);
    @(posedge clk); #1;
    push_a(0, 8'h0A, 1'b1, -1);
    push_a(3, 8'h3A, 1'b1, 3);
    wait_idle(1'b0, 400, "t5_wait");

    // 6: two-byte bursts from requesters 1 and 3
    @(posedge clk); #1;
    d0 = done_a;
    push_a(1, 8'h1B, 1'b0, -1);
    push_a(1, 8'h1C, 1'b1, 2);
    push_a(3, 8'h3B, 1'b0, 3);
    push_a(3, 8'h3C, 1'b1, 2);
    wait_idle(1'b0, 400, "t6_wait");
    chk("t6_done", done_a - d0, 4);

    chk("exp_a_left", exp_a.size(), 0);
    chk("exp_b_left", exp_b.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
